// File: rtl/awg_multichannel_core.sv
// Multi-channel DDS waveform core: per-channel NCO, shaper, scaler and burst control.
// Shadow configuration is committed to every channel together on the update strobe.
module awg_multichannel_core #(
   parameter int unsigned N_CH    = 2,
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned DAC_W   = 12,
   parameter int unsigned BURST_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [3:0]              wr_ch,
   input  logic [2:0]              wr_addr,
   input  logic [31:0]             wr_data,
   input  logic                    update,
   input  logic                    sync,
   input  logic [N_CH-1:0]         trig,
   output logic [N_CH*DAC_W-1:0]   dac_out,
   output logic [N_CH-1:0]         busy,
   output logic [N_CH-1:0]         wrap
);
   localparam int unsigned C_W    = DAC_W + 1;
   localparam int unsigned PROD_W = 2 * DAC_W + 2;
   localparam int unsigned SUM_W  = DAC_W + 3;
   localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic                     wr_hit;
      logic [PHASE_W-1:0]       sh_freq, sh_phase, freq, phase_off;
      logic [2:0]               sh_mode, mode;
      logic [DAC_W-1:0]         sh_duty, sh_amp, duty, amp;
      logic [C_W-1:0]           sh_offset, offset;
      logic [BURST_W-1:0]       sh_burst, burst_cnt;

      state_t                   state_q, state_d;
      logic                     burst_en, running_c, start_c, step_c, done_c;
      logic [BURST_W-1:0]       cnt_q;
      logic [PHASE_W-1:0]       acc_q, sum_c;
      logic                     carry_c, wrap_q;

      logic [DAC_W-1:0]         p_c, s_c, w_c, w_q, sat_c, dac_q;
      logic signed [C_W-1:0]    c_c, y_c, y_q;
      logic signed [PROD_W-1:0] prod_c;
      logic signed [SUM_W-1:0]  o_c;

      assign wr_hit = wr_en && (wr_ch == 4'(k));

      // Shadow register file, written field-truncated
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sh_freq   <= '0;
            sh_phase  <= '0;
            sh_mode   <= '0;
            sh_duty   <= '0;
            sh_amp    <= '0;
            sh_offset <= '0;
            sh_burst  <= '0;
         end else if (wr_hit) begin
            case (wr_addr)
               3'd0:    sh_freq   <= PHASE_W'(wr_data);
               3'd1:    sh_phase  <= PHASE_W'(wr_data);
               3'd2:    sh_mode   <= wr_data[2:0];
               3'd3:    sh_duty   <= DAC_W'(wr_data);
               3'd4:    sh_amp    <= DAC_W'(wr_data);
               3'd5:    sh_offset <= C_W'(wr_data);
               3'd6:    sh_burst  <= BURST_W'(wr_data);
               default: ;
            endcase
         end
      end

      // Active copy; a write on the update cycle only reaches the shadow
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            freq      <= '0;
            phase_off <= '0;
            mode      <= '0;
            duty      <= '0;
            amp       <= '0;
            offset    <= '0;
            burst_cnt <= '0;
         end else if (update) begin
            freq      <= sh_freq;
            phase_off <= sh_phase;
            mode      <= sh_mode;
            duty      <= sh_duty;
            amp       <= sh_amp;
            offset    <= sh_offset;
            burst_cnt <= sh_burst;
         end
      end

      assign burst_en           = mode[2];
      assign {carry_c, sum_c}   = {1'b0, acc_q} + {1'b0, freq};

      always_ff @(posedge clk or posedge rst) begin
         if (rst) state_q <= IDLE;
         else     state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         case (state_q)
            IDLE: if (burst_en && trig[k] && (burst_cnt != '0)) state_d = RUN;
            RUN: begin
               if (!burst_en)                                           state_d = IDLE;
               else if (carry_c && !sync && (cnt_q == BURST_W'(1)))     state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      always_comb begin
         running_c = !burst_en || (state_q == RUN);
         start_c   = (state_q == IDLE) && (state_d == RUN);
         step_c    = (state_q == RUN) && burst_en && carry_c && !sync;
         done_c    = step_c && (state_d == IDLE);
      end

      // Phase accumulator and burst period counter
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            wrap_q <= running_c && carry_c && !sync;
            if (sync || done_c || !running_c) acc_q <= '0;
            else                              acc_q <= sum_c;
            if (start_c)     cnt_q <= burst_cnt;
            else if (step_c) cnt_q <= cnt_q - BURST_W'(1);
         end
      end

      always_comb begin
         p_c = DAC_W'((acc_q + phase_off) >> (PHASE_W - DAC_W));
         s_c = {p_c[DAC_W-2:0], 1'b0};
         w_c = MID;
         case (mode[1:0])
            2'b00:   w_c = p_c;
            2'b01:   w_c = p_c[DAC_W-1] ? ~s_c : s_c;
            2'b10:   w_c = (p_c < duty) ? '1 : '0;
            default: w_c = MID;
         endcase
      end

      // Centre, scale by amp with floor shift, then add offset and clamp
      always_comb begin
         c_c    = $signed({1'b0, w_q}) - $signed({1'b0, MID});
         prod_c = PROD_W'(c_c) * $signed(PROD_W'({1'b0, amp}));
         y_c    = C_W'(prod_c >>> DAC_W);
         o_c    = SUM_W'(y_q) + SUM_W'({1'b0, MID}) + SUM_W'($signed(offset));
         if (o_c[SUM_W-1])             sat_c = '0;
         else if (|o_c[SUM_W-2:DAC_W]) sat_c = '1;
         else                          sat_c = o_c[DAC_W-1:0];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            w_q   <= '0;
            y_q   <= '0;
            dac_q <= MID;
         end else begin
            w_q   <= w_c;
            y_q   <= y_c;
            dac_q <= sat_c;
         end
      end

      assign dac_out[k*DAC_W +: DAC_W] = dac_q;
      assign busy[k]                   = (state_q == RUN);
      assign wrap[k]                   = wrap_q;
   end

endmodule

// File: tb/tb_awg_multichannel_core.sv
// Directed bench for awg_multichannel_core with a delayed-sample scoreboard.
module tb_awg_multichannel_core;
   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_ch;
   logic [2:0]  wr_addr;
   logic [31:0] wr_data;
   logic        update;
   logic        sync;
   logic [1:0]  trig;
   logic [23:0] dac_out;
   logic [1:0]  busy;
   logic [1:0]  wrap;

   int n_cmp = 0;
   int n_err = 0;
   int nb, nw;
   logic [31:0] s_reg [2][8] = '{default: '0};
   logic [31:0] a_reg [2][8] = '{default: '0};
   logic [31:0] acc_m [2];
   logic [23:0] sb [$];

   awg_multichannel_core #(.N_CH(2), .PHASE_W(32), .DAC_W(12), .BURST_W(16)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
      .wr_data(wr_data), .update(update), .sync(sync), .trig(trig),
      .dac_out(dac_out), .busy(busy), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic commit();
      for (int c = 0; c < 2; c++)
         for (int a = 0; a < 8; a++) a_reg[c][a] = s_reg[c][a];
   endtask

   // One register write; with upd the same cycle also carries update+sync
   task automatic wr(input int ch, input int addr, input logic [31:0] data, input bit upd);
      wr_en = 1'b1; wr_ch = 4'(ch); wr_addr = 3'(addr); wr_data = data;
      update = upd; sync = upd;
      if (upd) commit();
      if (ch < 2 && addr != 7) s_reg[ch][addr] = data;
      tick();
      wr_en = 1'b0; update = 1'b0; sync = 1'b0;
   endtask

   task automatic upd_sync();
      update = 1'b1; sync = 1'b1;
      commit();
      tick();
      update = 1'b0; sync = 1'b0;
   endtask

   task automatic sync_only();
      sync = 1'b1;
      tick();
      sync = 1'b0;
   endtask

   function automatic logic [11:0] model(input logic [31:0] acc, input int ch);
      logic [31:0]        ph;
      logic signed [12:0] off13;
      int p, w, y, o;
      ph    = acc + a_reg[ch][1];
      p     = int'(ph[31:20]);
      off13 = a_reg[ch][5][12:0];
      case (a_reg[ch][2][1:0])
         2'd0:    w = p;
         2'd1:    w = (p < 2048) ? 2 * p : 8191 - 2 * p;
         2'd2:    w = (p < int'(a_reg[ch][3][11:0])) ? 4095 : 0;
         default: w = 2048;
      endcase
      y = ((w - 2048) * int'(a_reg[ch][4][11:0])) >>> 12;
      o = y + 2048 + int'(off13);
      if (o < 0)         o = 0;
      else if (o > 4095) o = 4095;
      return 12'(o);
   endfunction

   // Free-running window starting on the cycle after a sync edge
   task automatic window(input int n, input string tag);
      logic [1:0]  wexp;
      logic [32:0] s;
      sb.delete();
      wexp = '0;
      for (int c = 0; c < 2; c++) acc_m[c] = '0;
      for (int i = 0; i < n; i++) begin
         sb.push_back({model(acc_m[1], 1), model(acc_m[0], 0)});
         if (sb.size() > 3) chk(tag, 32'(dac_out), 32'(sb.pop_front()));
         chk("wrap", 32'(wrap), 32'(wexp));
         tick();
         for (int c = 0; c < 2; c++) begin
            s        = {1'b0, acc_m[c]} + {1'b0, a_reg[c][0]};
            acc_m[c] = s[31:0];
            wexp[c]  = s[32];
         end
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
      update = 1'b0; sync = 1'b0; trig = '0;
      repeat (3) tick();
      chk("rst_dac", 32'(dac_out), 32'h0080_0800);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      rst = 1'b0;
      repeat (6) tick();
      chk("idle_dac", 32'(dac_out), 32'h0080_0800);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_wrap", 32'(wrap), 32'd0);

      // Saw on ch0
      wr(0, 0, 32'h0100_0000, 1'b0);
      wr(0, 4, 32'h0000_0FFF, 1'b0);
      wr(0, 2, 32'h0, 1'b0);
      upd_sync();
      window(300, "saw");

      // Square with positive then negative offset saturation
      wr(0, 3, 32'h800, 1'b0);
      wr(0, 2, 32'h2, 1'b0);
      wr(0, 5, 32'd1000, 1'b0);
      upd_sync();
      window(300, "sq_pos");
      wr(0, 5, 32'hFFFF_F448, 1'b0);
      upd_sync();
      window(300, "sq_neg");

      // Shadow writes stay inactive until an update
      wr(0, 2, 32'h0, 1'b0);
      wr(0, 5, 32'h0, 1'b0);
      wr(0, 0, 32'h0200_0000, 1'b0);
      sync_only();
      window(100, "shadow_hold");
      wr(0, 0, 32'h0080_0000, 1'b1);
      window(200, "wr_with_upd");
      upd_sync();
      window(300, "new_freq");

      // Triggered burst on ch1
      wr(1, 0, 32'h0400_0000, 1'b0);
      wr(1, 4, 32'h0000_0FFF, 1'b0);
      wr(1, 6, 32'd3, 1'b0);
      wr(1, 2, 32'h4, 1'b0);
      upd_sync();
      repeat (5) tick();
      chk("burst_pre", 32'(busy[1]), 32'd0);
      trig = 2'b10;
      tick();
      trig = 2'b00;
      chk("busy_rise", 32'(busy[1]), 32'd1);
      nb = 0; nw = 0;
      for (int i = 0; i < 260; i++) begin
         nb += int'(busy[1]);
         nw += int'(wrap[1]);
         if (i == 100) trig = 2'b10;
         tick();
         trig = 2'b00;
      end
      chk("burst_busy_cycles", 32'(nb), 32'd192);
      chk("burst_wraps", 32'(nw), 32'd3);
      chk("burst_done", 32'(busy[1]), 32'd0);
      chk("burst_idle_dac", 32'(dac_out[23:12]), 32'(model(32'h0, 1)));

      // Trigger with zero burst count is ignored
      wr(1, 6, 32'd0, 1'b0);
      upd_sync();
      trig = 2'b10;
      tick();
      trig = 2'b00;
      chk("zero_cnt_busy", 32'(busy[1]), 32'd0);
      nw = 0;
      for (int i = 0; i < 80; i++) begin
         nw += int'(wrap[1]);
         tick();
      end
      chk("zero_cnt_wraps", 32'(nw), 32'd0);

      // Asynchronous reset in the middle of a burst
      wr(1, 6, 32'd3, 1'b0);
      upd_sync();
      trig = 2'b10;
      tick();
      trig = 2'b00;
      repeat (20) tick();
      chk("pre_rst_busy", 32'(busy[1]), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_dac", 32'(dac_out), 32'h0080_0800);
      chk("mid_rst_wrap", 32'(wrap), 32'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 2; c++)
         for (int a = 0; a < 8; a++) begin
            s_reg[c][a] = '0;
            a_reg[c][a] = '0;
         end
      repeat (3) tick();

      // Phase-offset channel leads by a quarter period; channel 2 does not exist
      wr(0, 0, 32'h0100_0000, 1'b0);
      wr(0, 4, 32'h0000_0FFF, 1'b0);
      wr(1, 0, 32'h0100_0000, 1'b0);
      wr(1, 4, 32'h0000_0FFF, 1'b0);
      wr(1, 1, 32'h4000_0000, 1'b0);
      wr(2, 4, 32'h0, 1'b0);
      upd_sync();
      window(300, "phase");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
